// File: rtl/rgb_sched_pkg.sv
// Shared definitions for the RGB LED scheduler.
//   sched_state_e : arbiter state encoding (IDLE/HOLD/RELEASE)
//   CH_R/G/B      : bit position of each colour channel on led[2:0] and
//                   channel index inside one requester's {R,G,B} slice
//   color_slice() : extracts one requester's {R,G,B} word from the flat
//                   colour bus (bus is zero-extended to the package maximum)
package rgb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  localparam int unsigned CH_R = 2;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 0;

  localparam int unsigned MAX_REQ      = 16;
  localparam int unsigned MAX_PWM_BITS = 16;
  localparam int unsigned MAX_BUS_W    = MAX_REQ * 3 * MAX_PWM_BITS;

  typedef logic [3*MAX_PWM_BITS-1:0] rgb_slice_t;
  typedef logic [MAX_BUS_W-1:0]      color_bus_t;

  // Requester idx occupies bits [idx*3*pwm_bits +: 3*pwm_bits]; caller
  // truncates the result to its own 3*pwm_bits width.
  function automatic rgb_slice_t color_slice(input color_bus_t  bus,
                                             input int unsigned idx,
                                             input int unsigned pwm_bits);
    return rgb_slice_t'(bus >> (idx * 3 * pwm_bits));
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM with double-buffered duty registers.
//   clk, rst          : clock, asynchronous active-high reset
//   duty_r/g/b        : target duty; captured only at the period boundary
//   led[2:0]          : registered active-low drive {R,G,B}
module rgb_pwm
  import rgb_sched_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_r,
  input  logic [PWM_BITS-1:0] duty_g,
  input  logic [PWM_BITS-1:0] duty_b,
  output logic [2:0]          led
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
  logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
  logic [PWM_BITS-1:0] duty_b_q, duty_b_d;
  logic [2:0]          led_q, led_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    duty_r_d  = duty_r_q;
    duty_g_d  = duty_g_q;
    duty_b_d  = duty_b_q;
    // Active duty only changes on the last count so a period never mixes
    // two colours.
    if (pwm_cnt_q == '1) begin
      duty_r_d = duty_r;
      duty_g_d = duty_g;
      duty_b_d = duty_b;
    end
    led_d       = '1;
    led_d[CH_R] = ~(pwm_cnt_q < duty_r_q);
    led_d[CH_G] = ~(pwm_cnt_q < duty_g_q);
    led_d[CH_B] = ~(pwm_cnt_q < duty_b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      duty_r_q  <= '0;
      duty_g_q  <= '0;
      duty_b_q  <= '0;
      led_q     <= '1;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_r_q  <= duty_r_d;
      duty_g_q  <= duty_g_d;
      duty_b_q  <= duty_b_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_led_scheduler.sv
// Shares one RGB LED between N_REQ requesters via req/gnt.
//   clk, rst : clock, asynchronous active-high reset
//   req      : level request per requester (index 0 highest priority)
//   color    : flat {R,G,B} per requester, requester i in slice i
//   gnt      : registered one-hot grant; busy = |gnt
//   led[2:0] : active-low {R,G,B} PWM drive
// Build option: define RGB_LED_SCHED_RR_EN for round-robin arbitration
// (search starts after the last owner); default is fixed priority.
module rgb_led_scheduler
  import rgb_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned HOLD_CYCLES = 1200000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*3*PWM_BITS-1:0] color,
  output logic [N_REQ-1:0]            gnt,
  output logic                        busy,
  output logic [2:0]                  led
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
`ifdef RGB_LED_SCHED_RR_EN
  logic [IDX_W-1:0]     start_q, start_d;
`endif

  // Winner search: rotate from the search start, first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef RGB_LED_SCHED_RR_EN
      cand = IDX_W'((32'(start_q) + k) % N_REQ);
`else
      cand = IDX_W'(k);
`endif
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
`ifdef RGB_LED_SCHED_RR_EN
    start_d    = start_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d        = HOLD;
          owner_d        = win_idx;
          hold_cnt_d     = '0;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
`ifdef RGB_LED_SCHED_RR_EN
          start_d        = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST && !req[owner_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
`ifdef RGB_LED_SCHED_RR_EN
      start_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
`ifdef RGB_LED_SCHED_RR_EN
      start_q    <= start_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign busy = |gnt_q;

  // Colour path: owner's colour is sampled live while holding, else dark.
  color_bus_t              color_ext;
  logic [3*PWM_BITS-1:0]   tgt;
  logic [PWM_BITS-1:0]     duty_r, duty_g, duty_b;

  always_comb begin
    color_ext                         = '0;
    color_ext[N_REQ*3*PWM_BITS-1:0]   = color;
    tgt = (3*PWM_BITS)'(color_slice(color_ext, 32'(owner_q), PWM_BITS));
    if (state_q == HOLD) begin
      duty_r = tgt[CH_R*PWM_BITS +: PWM_BITS];
      duty_g = tgt[CH_G*PWM_BITS +: PWM_BITS];
      duty_b = tgt[CH_B*PWM_BITS +: PWM_BITS];
    end else begin
      duty_r = '0;
      duty_g = '0;
      duty_b = '0;
    end
  end

  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .duty_r (duty_r),
    .duty_g (duty_g),
    .duty_b (duty_b),
    .led    (led)
  );

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Scoreboard bench for rgb_led_scheduler (N_REQ=3, PWM_BITS=4, HOLD=16).
// A reference process predicts grant events and per-period LED on-times;
// a monitor process compares them as the DUT presents them.
module tb_rgb_led_scheduler;

  localparam int N   = 3;
  localparam int W   = 4;
  localparam int H   = 16;
  localparam int PER = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*3*W-1:0] color = '0;
  logic [N-1:0]     gnt;
  logic             busy;
  logic [2:0]       led;

  rgb_led_scheduler #(
    .N_REQ(N),
    .PWM_BITS(W),
    .HOLD_CYCLES(H)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .color (color),
    .gnt   (gnt),
    .busy  (busy),
    .led   (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { logic [N-1:0] val; int at; } gnt_ev_t;
  typedef struct { int r; int g; int b; } duty_t;
  gnt_ev_t gnt_exp[$];
  duty_t   pwm_exp[$];

  // channel: 2=R, 1=G, 0=B
  function automatic int col(int i, int ch);
    return int'(color[(i*3+ch)*W +: W]);
  endfunction

  // Reference: a grant lasts at least H cycles and ends once the owner's
  // request is gone; one dead cycle follows; LED on-time per period equals
  // the owner's colour as seen on the last cycle of the previous period.
  initial begin : model
    int owner, age, cool, rr_next, start, w;
    owner = -1; age = 0; cool = 0; rr_next = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0; owner = -1; age = 0; cool = 0; rr_next = 0;
        gnt_exp.delete();
        pwm_exp.delete();
        pwm_exp.push_back('{0, 0, 0});
      end else begin
        cyc++;
        if (cyc % PER == 0) begin
          if (owner >= 0) pwm_exp.push_back('{col(owner, 2), col(owner, 1), col(owner, 0)});
          else            pwm_exp.push_back('{0, 0, 0});
        end
        if (owner >= 0) begin
          if (age >= H-1 && !req[owner]) begin
            owner = -1;
            cool  = 1;
            gnt_exp.push_back('{'0, cyc});
          end else age++;
        end else if (cool > 0) begin
          cool--;
        end else if (req != '0) begin
`ifdef RGB_LED_SCHED_RR_EN
          start = rr_next;
`else
          start = 0;
`endif
          w = -1;
          for (int i = 0; i < N; i++)
            if (w < 0 && req[(start + i) % N]) w = (start + i) % N;
          owner   = w;
          age     = 0;
          rr_next = (w + 1) % N;
          gnt_exp.push_back('{N'(1 << w), cyc});
        end
      end
    end
  end

  initial begin : monitor
    logic [N-1:0] prev;
    int lr, lg, lb;
    gnt_ev_t e;
    duty_t   d;
    prev = '0; lr = 0; lg = 0; lb = 0;
    forever begin
      @(negedge clk);
      if (rst || cyc == 0) begin
        prev = '0; lr = 0; lg = 0; lb = 0;
      end else begin
        if (gnt !== prev) begin
          checks++;
          if (gnt_exp.size() == 0) begin
            errors++;
            $display("FAIL gnt_event: got gnt=%b busy=%b at cycle %0d, required no change", gnt, busy, cyc);
          end else begin
            e = gnt_exp.pop_front();
            if (gnt !== e.val || cyc != e.at || busy !== (e.val != '0)) begin
              errors++;
              $display("FAIL gnt_event: got gnt=%b busy=%b at cycle %0d, required gnt=%b busy=%b at cycle %0d",
                       gnt, busy, cyc, e.val, (e.val != '0), e.at);
            end
          end
          prev = gnt;
        end
        lr += int'(!led[2]);
        lg += int'(!led[1]);
        lb += int'(!led[0]);
        if (cyc % PER == 0) begin
          checks++;
          if (pwm_exp.size() == 0) begin
            errors++;
            $display("FAIL pwm_period: no expected period at cycle %0d (got R=%0d G=%0d B=%0d)", cyc, lr, lg, lb);
          end else begin
            d = pwm_exp.pop_front();
            if (lr != d.r || lg != d.g || lb != d.b) begin
              errors++;
              $display("FAIL pwm_period: cycle %0d on-counts got R=%0d G=%0d B=%0d, required R=%0d G=%0d B=%0d",
                       cyc, lr, lg, lb, d.r, d.g, d.b);
            end
          end
          lr = 0; lg = 0; lb = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_color(input int i, input int r, input int g, input int b);
    color[(i*3+2)*W +: W] = W'(r);
    color[(i*3+1)*W +: W] = W'(g);
    color[(i*3+0)*W +: W] = W'(b);
  endtask

  task automatic wait_gnt(output int idx);
    idx = -1;
    for (int t = 0; t < 200 && idx < 0; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
    end
    if (idx < 0) begin
      checks++; errors++;
      $display("FAIL wait_gnt: got gnt=%b after 200 cycles, required a grant", gnt);
    end
  endtask

  task automatic wait_gnt_low();
    int t;
    t = 0;
    while (gnt != '0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (gnt != '0) begin
      checks++; errors++;
      $display("FAIL wait_release: got gnt=%b after 200 cycles, required 0", gnt);
    end
  endtask

  initial begin : stim
    int idx, exp_idx, t;
    tick(3);
    rst = 1'b0;

    // single request, fixed colour
    set_color(1, 4'hF, 4'h0, 4'h8);
    req = 3'b010;
    wait_gnt(idx);
    tick(50);
    req = 3'b000;
    wait_gnt_low();
    tick(20);

    // early drop: grant still lasts the full hold
    set_color(0, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    req = 3'b001;
    wait_gnt(idx);
    tick(3);
    req = 3'b000;
    wait_gnt_low();
    tick(40);

    // live colour changes at random points mid-period
    set_color(2, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    req = 3'b100;
    wait_gnt(idx);
    for (int k = 0; k < 6; k++) begin
      tick($urandom_range(1, 25));
      set_color(2, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    end
    req = 3'b000;
    wait_gnt_low();
    tick(20);

    // contention, then req[0] returns while index 2 is being served
    for (int i = 0; i < N; i++)
      set_color(i, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(idx);
      if (idx < 0) break;
      tick($urandom_range(1, 20));
      if (idx == 2) req[0] = 1'b1;
      req[idx] = 1'b0;
      wait_gnt_low();
    end
    req = 3'b000;
    tick(20);

    // asynchronous reset while an LED channel is lit
    set_color(0, 4'hF, 4'hF, 4'hF);
    req = 3'b001;
    wait_gnt(idx);
    t = 0;
    while (led == 3'b111 && t < 100) begin
      @(negedge clk);
      t++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led !== 3'b111) begin errors++; $display("FAIL async_reset_led: got %b, required 111", led); end
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL async_reset_gnt: got %b, required 000", gnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b, required 0", busy); end
    req = 3'b000;
    tick(2);
    rst = 1'b0;
    tick(30);

    // held pair, owner drops and re-requests each round
    set_color(0, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    set_color(1, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    req = 3'b011;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(idx);
      if (idx < 0) break;
`ifdef RGB_LED_SCHED_RR_EN
      exp_idx = k % 2;
`else
      exp_idx = 0;
`endif
      checks++;
      if (idx != exp_idx) begin
        errors++;
        $display("FAIL held_pair_order: round %0d got index %0d, required %0d", k, idx, exp_idx);
      end
      tick($urandom_range(2, 20));
      req[idx] = 1'b0;
      wait_gnt_low();
      req[idx] = 1'b1;
    end
    req = 3'b000;
    tick(40);

    checks++;
    if (gnt_exp.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unobserved grant events, required 0", gnt_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
